// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron array: one shared saturating Q-format datapath
// sweeps all neurons, one per clock, emitting per-spike events and a done pulse.
module izhikevich_array #(
   parameter int N           = 32,
   parameter int Q           = 16,
   parameter int NUM_NEURONS = 8,
   parameter int IDX_W       = $clog2(NUM_NEURONS),
   parameter int REFRACTORY  = 2,
   parameter int REF_W       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [N-1:0]    a,
   input  logic signed [N-1:0]    b,
   input  logic signed [N-1:0]    c,
   input  logic signed [N-1:0]    d,
   input  logic signed [N-1:0]    v_th,
   input  logic signed [N-1:0]    step,
   input  logic                   start,
   input  logic                   wr_en,
   input  logic [1:0]             wr_sel,
   input  logic [IDX_W-1:0]       wr_addr,
   input  logic signed [N-1:0]    wr_data,
   input  logic [IDX_W-1:0]       rd_addr,
   output logic signed [N-1:0]    rd_v,
   output logic signed [N-1:0]    rd_w,
   output logic                   busy,
   output logic                   spike_valid,
   output logic [IDX_W-1:0]       spike_idx,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   done,
   output logic [31:0]            sweep_count
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   localparam logic signed [2*N-1:0] SAT_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [2*N-1:0] SAT_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};
   localparam logic signed [N-1:0]   K_004   = N'((4 * (2 ** Q) + 50) / 100);
   localparam logic signed [N-1:0]   K_5     = N'(5 * (2 ** Q));
   localparam logic signed [N-1:0]   K_140   = N'(140 * (2 ** Q));

   function automatic logic signed [2*N-1:0] sx(input logic signed [N-1:0] x);
      return {{N{x[N-1]}}, x};
   endfunction

   function automatic logic signed [N-1:0] sat(input logic signed [2*N-1:0] x);
      if (x > SAT_MAX)      return SAT_MAX[N-1:0];
      else if (x < SAT_MIN) return SAT_MIN[N-1:0];
      else                  return x[N-1:0];
   endfunction

   function automatic logic signed [N-1:0] qadd(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
      return sat(sx(x) + sx(y));
   endfunction

   function automatic logic signed [N-1:0] qsub(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
      return sat(sx(x) - sx(y));
   endfunction

   function automatic logic signed [N-1:0] qmul(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
      logic signed [2*N-1:0] p;
      p = sx(x) * sx(y);
      return sat(p >>> Q);
   endfunction

   state_t                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic signed [N-1:0]      v_q   [NUM_NEURONS];
   logic signed [N-1:0]      w_q   [NUM_NEURONS];
   logic signed [N-1:0]      i_q   [NUM_NEURONS];
   logic [REF_W-1:0]         ref_q [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]   flags_q;
   logic [NUM_NEURONS-1:0]   spike_vec_q;
   logic                     busy_q, spike_valid_q, done_q;
   logic [IDX_W-1:0]         spike_idx_q;
   logic [31:0]              sweep_count_q;
   logic signed [N-1:0]      rd_v_q, rd_w_q;

   logic signed [N-1:0]      cur_v, cur_w, cur_i, poly, dv, dw;
   logic [REF_W-1:0]         cur_ref;
   logic signed [N-1:0]      v_d, w_d;
   logic [REF_W-1:0]         ref_d;
   logic                     spike_d;

   // Datapath for the neuron under the sweep pointer, on its pre-update state
   always_comb begin
      cur_v   = v_q[idx_q];
      cur_w   = w_q[idx_q];
      cur_i   = i_q[idx_q];
      cur_ref = ref_q[idx_q];
      poly    = qadd(qmul(qmul(K_004, cur_v), cur_v), qmul(K_5, cur_v));
      poly    = qadd(qsub(qadd(poly, K_140), cur_w), cur_i);
      dv      = qmul(step, poly);
      dw      = qmul(step, qmul(a, qsub(qmul(b, cur_v), cur_w)));
      v_d     = qadd(cur_v, dv);
      w_d     = qadd(cur_w, dw);
      ref_d   = cur_ref;
      spike_d = 1'b0;
      if (cur_ref != '0) begin
         v_d   = c;
         ref_d = cur_ref - REF_W'(1);
      end else if (cur_v > v_th) begin
         spike_d = 1'b1;
         v_d     = c;
         w_d     = qadd(cur_w, d);
         ref_d   = REF_W'(REFRACTORY);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
            v_q[k]   <= c;
            w_q[k]   <= '0;
            i_q[k]   <= '0;
            ref_q[k] <= '0;
         end
         state_q       <= S_IDLE;
         idx_q         <= '0;
         flags_q       <= '0;
         spike_vec_q   <= '0;
         busy_q        <= 1'b0;
         spike_valid_q <= 1'b0;
         spike_idx_q   <= '0;
         done_q        <= 1'b0;
         sweep_count_q <= '0;
         rd_v_q        <= '0;
         rd_w_q        <= '0;
      end else begin
         spike_valid_q <= 1'b0;
         done_q        <= 1'b0;
         rd_v_q        <= v_q[rd_addr];
         rd_w_q        <= w_q[rd_addr];
         case (state_q)
            S_IDLE: begin
               // busy stays high through the done pulse, so the first IDLE cycle only drops it
               if (busy_q) begin
                  busy_q <= 1'b0;
               end else begin
                  if (wr_en) begin
                     case (wr_sel)
                        2'd0:    v_q[wr_addr]   <= wr_data;
                        2'd1:    w_q[wr_addr]   <= wr_data;
                        2'd2:    i_q[wr_addr]   <= wr_data;
                        default: ref_q[wr_addr] <= '0;
                     endcase
                  end
                  if (start) begin
                     state_q <= S_SWEEP;
                     idx_q   <= '0;
                     flags_q <= '0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_SWEEP: begin
               v_q[idx_q]   <= v_d;
               w_q[idx_q]   <= w_d;
               ref_q[idx_q] <= ref_d;
               if (spike_d) begin
                  spike_valid_q  <= 1'b1;
                  spike_idx_q    <= idx_q;
                  flags_q[idx_q] <= 1'b1;
               end
               if (idx_q == IDX_W'(NUM_NEURONS - 1)) state_q <= S_DONE;
               else                                  idx_q   <= idx_q + 1'b1;
            end
            S_DONE: begin
               done_q        <= 1'b1;
               spike_vec_q   <= flags_q;
               sweep_count_q <= sweep_count_q + 32'd1;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_v        = rd_v_q;
   assign rd_w        = rd_w_q;
   assign busy        = busy_q;
   assign spike_valid = spike_valid_q;
   assign spike_idx   = spike_idx_q;
   assign spike_vec   = spike_vec_q;
   assign done        = done_q;
   assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_izhikevich_array.sv
// Scoreboard bench for izhikevich_array: a behavioural array model queues expected
// spike, done and readback events; a negedge monitor pops and compares them.
module tb_izhikevich_array;
   localparam int NN = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, wr_en;
   logic [31:0] a, b, c, d, v_th, step, wr_data;
   logic [1:0]  wr_sel;
   logic [2:0]  wr_addr, rd_addr;
   logic [31:0] rd_v, rd_w, sweep_count;
   logic        busy, spike_valid, done;
   logic [2:0]  spike_idx;
   logic [7:0]  spike_vec;

   izhikevich_array #(.N(32), .Q(16), .NUM_NEURONS(NN), .REFRACTORY(2), .REF_W(4)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .v_th(v_th), .step(step),
      .start(start), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_v(rd_v), .rd_w(rd_w), .busy(busy), .spike_valid(spike_valid),
      .spike_idx(spike_idx), .spike_vec(spike_vec), .done(done), .sweep_count(sweep_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   longint      mv [NN];
   longint      mw [NN];
   longint      mi [NN];
   int          mref [NN];
   logic [31:0] mcount;

   typedef struct { int idx; int cyc; } spk_t;
   typedef struct { int cyc; logic [7:0] vec; logic [31:0] cnt; } done_t;
   typedef struct { int cyc; int idx; logic [31:0] v; logic [31:0] w; } rd_t;
   spk_t  spk_q[$];
   done_t done_q[$];
   rd_t   rd_q[$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endfunction

   function automatic longint clamp(longint x);
      if (x > 64'sd2147483647)  return 64'sd2147483647;
      if (x < -64'sd2147483648) return -64'sd2147483648;
      return x;
   endfunction

   function automatic longint qmul(longint x, longint y);
      return clamp((x * y) >>> 16);
   endfunction

   function automatic longint sx(logic [31:0] x);
      longint r;
      r = $signed(x);
      return r;
   endfunction

   function automatic void model_reset();
      for (int n = 0; n < NN; n++) begin
         mv[n] = sx(c); mw[n] = 0; mi[n] = 0; mref[n] = 0;
      end
      mcount = '0;
   endfunction

   // One sweep of the Izhikevich rules; queues the events the DUT must produce
   function automatic void model_sweep(int t);
      longint     v, w, f, dv, dw;
      logic [7:0] vec;
      spk_t       se;
      done_t      de;
      vec = '0;
      for (int n = 0; n < NN; n++) begin
         v  = mv[n];
         w  = mw[n];
         f  = clamp(qmul(qmul(2621, v), v) + qmul(5 * 65536, v));
         f  = clamp(clamp(clamp(f + 140 * 65536) - w) + mi[n]);
         dv = qmul(sx(step), f);
         dw = qmul(sx(step), qmul(sx(a), clamp(qmul(sx(b), v) - w)));
         if (mref[n] > 0) begin
            mv[n] = sx(c); mw[n] = clamp(w + dw); mref[n]--;
         end else if (v > sx(v_th)) begin
            mv[n] = sx(c); mw[n] = clamp(w + sx(d)); mref[n] = 2;
            vec[n] = 1'b1;
            se.idx = n; se.cyc = t + 1 + n;
            spk_q.push_back(se);
         end else begin
            mv[n] = clamp(v + dv); mw[n] = clamp(w + dw);
         end
      end
      mcount = mcount + 32'd1;
      de.cyc = t + NN + 1; de.vec = vec; de.cnt = mcount;
      done_q.push_back(de);
   endfunction

   always @(negedge clk) begin
      spk_t  se;
      done_t de;
      rd_t   re;
      if (spk_q.size() > 0 && spk_q[0].cyc < cyc) begin
         se = spk_q.pop_front();
         checks++; errors++;
         $display("FAIL spike_missing: idx %0d not seen by cycle %0d, required at %0d", se.idx, cyc, se.cyc);
      end
      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
         de = done_q.pop_front();
         checks++; errors++;
         $display("FAIL done_missing: none by cycle %0d, required at %0d", cyc, de.cyc);
      end
      if (spike_valid === 1'b1) begin
         if (spk_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spike_unexpected: got idx %0d at cycle %0d, required none", spike_idx, cyc);
         end else begin
            se = spk_q.pop_front();
            chk("spike_idx", 32'(spike_idx), se.idx);
            chk("spike_cycle", cyc, se.cyc);
         end
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
         end else begin
            de = done_q.pop_front();
            chk("done_cycle", cyc, de.cyc);
            chk("spike_vec", 32'(spike_vec), 32'(de.vec));
            chk("sweep_count", sweep_count, de.cnt);
         end
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
         re = rd_q.pop_front();
         chk($sformatf("rd_v[%0d]", re.idx), rd_v, re.v);
         chk($sformatf("rd_w[%0d]", re.idx), rd_w, re.w);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int sel, input int addr, input logic [31:0] data);
      wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = 3'(addr); wr_data = data;
      tick();
      wr_en = 1'b0;
      case (sel)
         0:       mv[addr] = sx(data);
         1:       mw[addr] = sx(data);
         2:       mi[addr] = sx(data);
         default: mref[addr] = 0;
      endcase
   endtask

   task automatic rd(input int idx);
      rd_t re;
      rd_addr = 3'(idx);
      re.cyc = cyc + 1; re.idx = idx; re.v = 32'(mv[idx]); re.w = 32'(mw[idx]);
      rd_q.push_back(re);
      tick();
   endtask

   task automatic rd_all();
      for (int n = 0; n < NN; n++) rd(n);
   endtask

   // poke holds start/wr_en high for the whole busy window; none of it may take effect
   task automatic sweep(input bit do_wr, input int waddr, input logic [31:0] wdata, input bit poke);
      int t, k;
      start = 1'b1;
      if (do_wr) begin
         wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 3'(waddr); wr_data = wdata;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
      t = cyc;
      if (do_wr) mv[waddr] = sx(wdata);
      model_sweep(t);
      chk("busy_rise", 32'(busy), 32'd1);
      if (poke) begin
         start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 3'd5; wr_data = 32'h0012_3400;
      end
      k = 0;
      while (busy === 1'b1 && k < 40) begin
         tick();
         k++;
      end
      start = 1'b0; wr_en = 1'b0;
      chk("busy_fall_cycle", cyc, t + NN + 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel, addr, tmp;
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      a = 32'h0000_051F; b = 32'h0000_3333; c = 32'hFFBF_0000; d = 32'h0008_0000;
      v_th = 32'h001E_0000; step = 32'h0000_8000;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sweep_count", sweep_count, 0);
      chk("rst_spike_vec", 32'(spike_vec), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_spike_valid", 32'(spike_valid), 0);
      chk("rst_rd_v", rd_v, 0);
      chk("rst_rd_w", rd_w, 0);
      rd_all();

      // single spike on neuron 3
      wr(1, 3, 32'h0);
      wr(0, 3, 32'h0023_0000);
      sweep(0, 0, 0, 0);
      chk("spike_bit3", 32'(spike_vec[3]), 1);
      rd(3);
      chk("spike_v3", rd_v, c);
      chk("spike_w3", rd_w, 32'h0008_0000);

      // refractory: two held sweeps, then it fires again
      wr(0, 3, 32'h0028_0000);
      sweep(0, 0, 0, 0);
      chk("refr1_bit3", 32'(spike_vec[3]), 0);
      rd(3);
      chk("refr1_v3", rd_v, c);
      sweep(0, 0, 0, 0);
      chk("refr2_bit3", 32'(spike_vec[3]), 0);
      rd(3);
      chk("refr2_v3", rd_v, c);
      wr(0, 3, 32'h0028_0000);
      sweep(0, 0, 0, 0);
      chk("refr3_bit3", 32'(spike_vec[3]), 1);

      // subthreshold neuron 0
      wr(3, 0, 32'h0);
      wr(0, 0, 32'hFFBF_0000);
      wr(1, 0, 32'hFFF3_0000);
      wr(2, 0, 32'h0);
      sweep(0, 0, 0, 0);
      chk("sub_bit0", 32'(spike_vec[0]), 0);
      rd(0);

      // saturation on neuron 1
      v_th = 32'h7FFF_FFFF;
      wr(3, 1, 32'h0);
      wr(0, 1, 32'h7FFF_0000);
      wr(2, 1, 32'h7FFF_0000);
      sweep(0, 0, 0, 0);
      rd(1);
      chk("sat_v1", rd_v, 32'h7FFF_FFFF);
      v_th = 32'h001E_0000;

      // start/write while busy are ignored
      sweep(0, 0, 0, 1);
      rd(5);

      // write and start in the same cycle: neuron 0 sees the new v
      wr(3, 0, 32'h0);
      sweep(1, 0, 32'h0028_0000, 0);
      chk("wrstart_bit0", 32'(spike_vec[0]), 1);

      // randomized writes and parameters
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 4; k++) begin
            sel  = int'($urandom_range(0, 3));
            addr = int'($urandom_range(0, NN - 1));
            case (sel)
               0:       tmp = (int'($urandom_range(0, 130)) - 90) * 65536 + int'($urandom_range(0, 65535));
               1:       tmp = (int'($urandom_range(0, 40)) - 20) * 65536 + int'($urandom_range(0, 65535));
               2:       tmp = int'($urandom_range(0, 20)) * 65536;
               default: tmp = 0;
            endcase
            wr(sel, addr, 32'(tmp));
         end
         v_th = 32'(int'($urandom_range(20, 40)) * 65536);
         d    = 32'(int'($urandom_range(0, 10)) * 65536);
         case ($urandom_range(0, 2))
            0:       step = 32'h0000_4000;
            1:       step = 32'h0000_8000;
            default: step = 32'h0001_0000;
         endcase
         sweep(1'($urandom_range(0, 1)), int'($urandom_range(0, NN - 1)),
               32'(int'($urandom_range(0, 80)) * 65536 - 32'h0032_0000), 0);
         rd_all();
      end

      // reset in the middle of a sweep (no neuron can fire with this threshold)
      v_th = 32'h7FFF_FFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_sweep_count", sweep_count, 0);
      chk("midrst_spike_vec", 32'(spike_vec), 0);
      rd_all();
      v_th = 32'h001E_0000;
      sweep(0, 0, 0, 0);
      rd_all();

      repeat (3) tick();
      chk("spike_queue_drained", spk_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/izhikevich_array.md
Name: izhikevich_array

Overview:
- Time-multiplexed Izhikevich neuron array, the successor to the single-neuron Izhikevich core.
- Holds per-neuron v, w, input current and refractory state for NUM_NEURONS neurons, and sweeps one shared fixed-point datapath over them, one neuron per clock.
- Adds saturating arithmetic, an absolute refractory period, a per-spike event stream and a busy/done handshake.
- Sits between the stimulus/weight logic (which writes currents) and spike routing (which consumes spike events).

Parameters:
- N, 32, total fixed-point word width (signed, two's complement).
- Q, 16, fractional bits.
- NUM_NEURONS, 8, neurons in the array (>=2).
- IDX_W, $clog2(NUM_NEURONS), neuron index width.
- REFRACTORY, 2, sweeps a neuron is held at c after spiking (0 = none).
- REF_W, 4, refractory counter width; must hold REFRACTORY.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- a, b, c, d  in  N each  shared Izhikevich parameters (Q format).
- v_th  in  N  spike threshold.
- step  in  N  integration step.
- start  in  1  begin one sweep; accepted only when busy=0.
- wr_en  in  1  state write strobe; accepted only when busy=0.
- wr_sel  in  2  write target: 0=v, 1=w, 2=i, 3=refractory counter clear.
- wr_addr  in  IDX_W  neuron index for write.
- wr_data  in  N  write data.
- rd_addr  in  IDX_W  readback index.
- rd_v, rd_w  out  N each  v and w of neuron rd_addr, registered, 1-cycle latency.
- busy  out  1  high while a sweep is in progress (SWEEP or DONE).
- spike_valid  out  1  one-cycle pulse per spiking neuron.
- spike_idx  out  IDX_W  index of the spiking neuron, valid with spike_valid.
- spike_vec  out  NUM_NEURONS  spike flags of the last completed sweep.
- done  out  1  one-cycle pulse at end of sweep.
- sweep_count  out  32  completed sweeps, wraps at 2^32.

Behaviour:
- Reset, synchronous on rst=1:
  - Every neuron: v=c (sampled at reset), w=0, i=0, ref=0.
  - FSM=IDLE; outputs busy, spike_valid, spike_idx, spike_vec, done, sweep_count, rd_v, rd_w all 0.
  - rst overrides start, writes and any in-progress sweep; the partially updated neurons keep no partial state.
- FSM states:
  - IDLE: start=1 -> SWEEP with idx=0. wr_en writes the neuron selected by wr_sel/wr_addr in that cycle.
  - SWEEP: update neuron idx each cycle. At idx=NUM_NEURONS-1 -> DONE, else idx+1.
  - DONE (1 cycle): done=1, spike_vec <= accumulated flags, sweep_count+1, then -> IDLE.
  - busy=1 in SWEEP and DONE. start and wr_en are ignored while busy (no queueing).
  - Latency: start accepted at cycle T gives done at T+NUM_NEURONS+1; busy falls the cycle after done.
- Arithmetic, per neuron, all in Q-format:
  - Multiply: full 2N product, arithmetic shift right by Q, then saturate to N bits.
  - Add/subtract: saturate to [-2^(N-1), 2^(N-1)-1]. No wraparound anywhere.
  - dv = step*(0.04*v*v + 5*v + 140 - w + i). Constants are rounded to Q fraction bits: 0.04 = 0x0000_0A3D at Q=16, 140 = 140<<Q.
  - dw = step*(a*(b*v - w)).
- Update rules for neuron idx in SWEEP, evaluated on its pre-update state:
  - ref>0: v<=c, w<=w+dw, ref<=ref-1, no spike.
  - else if signed v > v_th: spike. v<=c, w<=w+d, ref<=REFRACTORY. spike_valid=1 and spike_idx=idx on the next clock edge; flag idx set.
  - else: v<=v+dv, w<=w+dw.
- spike_vec holds between sweeps and is updated only in DONE. Neurons that did not spike read 0.
- Readback: rd_v/rd_w reflect state as of the previous edge (write or update); valid in any state.
- Same-cycle write in IDLE and rd_addr hit: readback returns the old value; the new value appears one cycle later.
- start and wr_en in the same IDLE cycle: the write takes effect and the sweep starts; neuron 0 sees the written value if wr_addr=0.

Test Plan:
- Reset with c=0xFFBF0000 (-65.0): all neurons read rd_v=0xFFBF0000 and rd_w=0. busy=0, sweep_count=0, spike_vec=0.
- Spike: write v[3]=0x00230000 (35.0), v_th=0x001E0000, d=0x00080000, w[3]=0, then start. spike_valid with spike_idx=3 exactly 4 cycles after start acceptance. After done: v[3]=c, w[3]=0x00080000, spike_vec=0x08, done at T+NUM_NEURONS+1.
- Refractory (REFRACTORY=2): after the spike above, write v[3]=0x00280000 and run 2 sweeps. No spike; v[3]=c after each. Third sweep with v[3]>v_th spikes again.
- Subthreshold: v=-65.0, w=-13.0 (0xFFF30000), i=0, step=0x00008000, a=0x0000051F, b=0x00003333. One sweep changes v by step*dv within 1 LSB of the bench's golden model; no spike.
- Saturation: v_th=0x7FFFFFFF, v=0x7FFF0000, i=0x7FFF0000. After the sweep v=0x7FFFFFFF, never negative.
- Handshake: start and wr_en asserted while busy are ignored, and state is unchanged by the write. rst asserted mid-sweep returns to IDLE and reset values on the next edge; sweep_count wraps from 0xFFFFFFFF to 0.
